// File: rtl/mem_arb_pkg.sv
// Shared types for the memory fill arbiter.
//   arb_state_e : arbiter FSM states
//   fill_tgt_e  : which cache a block fill is steered to
//   idx_width   : bits needed for a word index within a block
//   blk_bits    : low byte-address bits cleared to form a block base
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} arb_state_e;

  typedef enum logic {TGT_I, TGT_D} fill_tgt_e;

  function automatic int idx_width(input int words);
    return $clog2(words);
  endfunction

  // Word addresses are 2-byte aligned, so a block spans words*2 bytes.
  function automatic int blk_bits(input int words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/mem_fill_arbiter_fill_counter.sv
// Block-fill sequencing counters.
//   clk, rst      : clock, async active-high reset
//   clr           : hold both counters at zero (arbiter not filling)
//   issue_en      : fill in progress, advance the issue counter
//   ret_en        : a read word returned this cycle
//   base          : block base byte address
//   issue_active  : reads still to issue for this block
//   issue_addr    : address of the read issued this cycle
//   ret_idx       : word slot of the word returning this cycle
//   ret_last      : the returning word is the last of the block
module fill_counter
  import mem_arb_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              issue_en,
  input  logic              ret_en,
  input  logic [ADDR_W-1:0] base,
  output logic              issue_active,
  output logic [ADDR_W-1:0] issue_addr,
  output logic [IDX_W-1:0]  ret_idx,
  output logic              ret_last
);

  // Extra MSB on the issue counter marks "all reads issued" so issue stops
  // after the wrap instead of re-reading the block.
  logic [IDX_W:0]   issue_cnt;
  logic [IDX_W-1:0] ret_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (clr) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (issue_en && issue_active) issue_cnt <= issue_cnt + 1'b1;
      if (ret_en)                   ret_cnt   <= ret_cnt + 1'b1;
    end
  end

  assign issue_active = ~issue_cnt[IDX_W];
  assign issue_addr   = base + ADDR_W'({issue_cnt[IDX_W-1:0], 1'b0});
  assign ret_idx      = ret_cnt;
  assign ret_last     = &ret_cnt;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbiter / block-fill controller for the single-ported main memory.
// Serves I-cache misses, D-cache misses and D-side write-through stores.
//   clk, rst                     : clock, async active-high reset
//   icache_miss/_addr            : I miss request, held until icache_fill_done
//   dcache_miss/_addr            : D miss request, held until dcache_fill_done
//   dcache_wr_req/_addr/_data    : store request, held until dcache_wr_ack
//   mem_data_valid, mem_data_in  : read return from memory
//   mem_en/_wr/_addr/_data_out   : memory access port
//   fill_data, fill_word_idx     : returned word and its slot, to both caches
//   {i,d}cache_fill_valid/_done  : per-cache write strobe / last-word pulse
//   dcache_wr_ack                : store issued this cycle
//   {i,d}cache_busy              : arbiter currently serving that side
module mem_fill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               icache_miss,
  input  logic [ADDR_W-1:0]                  icache_miss_addr,
  input  logic                               dcache_miss,
  input  logic [ADDR_W-1:0]                  dcache_miss_addr,
  input  logic                               dcache_wr_req,
  input  logic [ADDR_W-1:0]                  dcache_wr_addr,
  input  logic [DATA_W-1:0]                  dcache_wr_data,
  input  logic                               mem_data_valid,
  input  logic [DATA_W-1:0]                  mem_data_in,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_data_out,
  output logic [DATA_W-1:0]                  fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
  output logic                               icache_fill_valid,
  output logic                               dcache_fill_valid,
  output logic                               icache_fill_done,
  output logic                               dcache_fill_done,
  output logic                               dcache_wr_ack,
  output logic                               icache_busy,
  output logic                               dcache_busy
);

  localparam int IDX_W = idx_width(WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] BASE_MASK =
    ~((ADDR_W'(1) << blk_bits(WORDS_PER_BLOCK)) - ADDR_W'(1));

  arb_state_e        state;
  fill_tgt_e         tgt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              in_fill, ret_en, fill_last;
  logic              issue_active, ret_last;
  logic [ADDR_W-1:0] issue_addr;
  logic [IDX_W-1:0]  ret_idx;

  assign in_fill   = (state == FILL_I) || (state == FILL_D);
  assign tgt       = (state == FILL_D) ? TGT_D : TGT_I;
  // Returns outside a fill (idle, store, or after a reset) are dropped here.
  assign ret_en    = in_fill && mem_data_valid;
  assign fill_last = ret_en && ret_last;

  fill_counter #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (!in_fill),
    .issue_en    (in_fill),
    .ret_en      (ret_en),
    .base        (base),
    .issue_active(issue_active),
    .issue_addr  (issue_addr),
    .ret_idx     (ret_idx),
    .ret_last    (ret_last)
  );

  // Store address/data are captured at grant so mem_* never depends
  // combinationally on the request inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // D side first: it belongs to the older instruction.
          if (dcache_miss) begin
            state <= FILL_D;
            base  <= dcache_miss_addr & BASE_MASK;
          end else if (dcache_wr_req) begin
            state     <= WRITE;
            wr_addr_q <= dcache_wr_addr;
            wr_data_q <= dcache_wr_data;
          end else if (icache_miss) begin
            state <= FILL_I;
            base  <= icache_miss_addr & BASE_MASK;
          end
        end
        FILL_I, FILL_D: if (fill_last) state <= IDLE;
        WRITE:          state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

  assign mem_en        = (in_fill && issue_active) || (state == WRITE);
  assign mem_wr        = (state == WRITE);
  assign mem_addr      = (state == WRITE)            ? wr_addr_q  :
                         (in_fill && issue_active)   ? issue_addr : '0;
  assign mem_data_out  = (state == WRITE) ? wr_data_q : '0;

  assign fill_data         = ret_en ? mem_data_in : '0;
  assign fill_word_idx     = in_fill ? ret_idx : '0;
  assign icache_fill_valid = ret_en && (tgt == TGT_I);
  assign dcache_fill_valid = ret_en && (tgt == TGT_D);
  assign icache_fill_done  = fill_last && (tgt == TGT_I);
  assign dcache_fill_done  = fill_last && (tgt == TGT_D);
  assign dcache_wr_ack     = (state == WRITE);
  assign icache_busy       = (state == FILL_I);
  assign dcache_busy       = (state == FILL_D) || (state == WRITE);

endmodule
